// File: rtl/voice_sum_mixer.sv
// Sums NVOICES time-multiplexed voice samples per frame, applies a right-shift gain
// and saturates the frame to DW bits, with clip and sync-error statistics.
module voice_sum_mixer #(
  parameter int NVOICES = 10,
  parameter int DW      = 24,
  parameter int SHIFT_W = 3,
  parameter int STAT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic [DW-1:0]        i_data,
  input  logic                 i_sync,
  input  logic [SHIFT_W-1:0]   i_shift,
  input  logic                 i_clr_stats,
  output logic [DW-1:0]        o_mixed,
  output logic                 o_rdy,
  output logic                 o_clip,
  output logic                 o_sync_err,
  output logic [STAT_W-1:0]    o_clip_count
);

  localparam int AW = DW + $clog2(NVOICES) + 1;
  localparam int CW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NVOICES - 1);
  localparam bit MULTI = (NVOICES > 1);
  localparam logic signed [AW-1:0] MAXV = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  logic [CW-1:0]          cnt;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   scaled;
  logic                   realign;
  logic                   close;
  logic [DW-1:0]          mixed_next;
  logic                   clip_next;

  // A single-voice frame has nothing to realign, so sync then just closes the frame.
  assign realign = clk_en & i_sync & MULTI;
  assign close   = clk_en & ~realign & (cnt == LAST);
  assign ext     = {{(AW - DW){i_data[DW-1]}}, i_data};
  assign sum     = acc + ext;
  assign scaled  = sum >>> i_shift;

  always_comb begin
    mixed_next = scaled[DW-1:0];
    clip_next  = 1'b0;
    if (scaled > MAXV) begin
      mixed_next = MAXV[DW-1:0];
      clip_next  = 1'b1;
    end else if (scaled < MINV) begin
      mixed_next = MINV[DW-1:0];
      clip_next  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= '0;
      o_mixed    <= '0;
      o_rdy      <= 1'b0;
      o_clip     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      o_rdy      <= close;
      o_sync_err <= realign & (cnt != '0);
      if (clk_en) begin
        if (realign) begin
          acc <= ext;
          cnt <= CW'(1);
        end else if (close) begin
          acc     <= '0;
          cnt     <= '0;
          o_mixed <= mixed_next;
          o_clip  <= clip_next;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Clear takes priority over a coincident clipping frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      o_clip_count <= '0;
    else if (i_clr_stats)
      o_clip_count <= '0;
    else if (close && clip_next && !(&o_clip_count))
      o_clip_count <= o_clip_count + STAT_W'(1);
  end

endmodule

// File: tb/tb_voice_sum_mixer.sv
// Scoreboard bench for voice_sum_mixer: a longint frame model queues expected
// outputs at stimulus time; the monitor pops and compares them on o_rdy.
module tb_voice_sum_mixer;
  localparam int N   = 10;
  localparam int DW  = 24;
  localparam int SW  = 3;
  localparam int STW = 8;
  localparam longint MAXV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (DW - 1));
  localparam longint CMAX = (64'sd1 <<< STW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           clk_en = 1'b0;
  logic [DW-1:0]  i_data = '0;
  logic           i_sync = 1'b0;
  logic [SW-1:0]  i_shift = '0;
  logic           i_clr_stats = 1'b0;
  logic [DW-1:0]  o_mixed;
  logic           o_rdy;
  logic           o_clip;
  logic           o_sync_err;
  logic [STW-1:0] o_clip_count;

  voice_sum_mixer #(.NVOICES(N), .DW(DW), .SHIFT_W(SW), .STAT_W(STW)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .i_data(i_data), .i_sync(i_sync),
    .i_shift(i_shift), .i_clr_stats(i_clr_stats), .o_mixed(o_mixed), .o_rdy(o_rdy),
    .o_clip(o_clip), .o_sync_err(o_sync_err), .o_clip_count(o_clip_count)
  );

  always #5 clk = ~clk;

  typedef struct { longint mixed; longint clip; longint count; } exp_t;
  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  int     m_cnt = 0;
  longint m_acc = 0;
  longint m_count = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every ready pulse must match the oldest queued frame.
  always @(negedge clk) begin
    if (!reset && o_rdy) begin
      if (sb.size() == 0) begin
        chk("rdy_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mixed", longint'($signed(o_mixed)), e.mixed);
        chk("clip", longint'(o_clip), e.clip);
        chk("clip_count", longint'(o_clip_count), e.count);
        $display("frame: mixed=%0d clip=%0d count=%0d", $signed(o_mixed), o_clip, o_clip_count);
      end
    end
  end

  // One clock of stimulus; the model predicts this edge's rdy/sync_err and frame result.
  task automatic drive(input bit en, input longint data, input bit sync, input bit clr);
    bit     exp_rdy;
    bit     exp_err;
    bit     clipped;
    longint sum;
    longint sc;
    exp_t   e;
    exp_rdy = 1'b0;
    exp_err = 1'b0;
    clipped = 1'b0;
    if (en) begin
      if (sync) begin
        exp_err = (m_cnt != 0);
        m_acc = data;
        m_cnt = 1;
      end else if (m_cnt == N - 1) begin
        sum = m_acc + data;
        sc = sum >>> i_shift;
        if (sc > MAXV) begin e.mixed = MAXV; clipped = 1'b1; end
        else if (sc < MINV) begin e.mixed = MINV; clipped = 1'b1; end
        else e.mixed = sc;
        e.clip = clipped;
        exp_rdy = 1'b1;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc += data;
        m_cnt++;
      end
    end
    if (clr) m_count = 0;
    else if (clipped && m_count < CMAX) m_count++;
    if (exp_rdy) begin
      e.count = m_count;
      sb.push_back(e);
    end
    clk_en = en;
    i_data = DW'(data);
    i_sync = sync;
    i_clr_stats = clr;
    @(posedge clk);
    #1;
    chk("rdy", longint'(o_rdy), longint'(exp_rdy));
    chk("sync_err", longint'(o_sync_err), longint'(exp_err));
  endtask

  task automatic frame(input longint v, input int shift);
    i_shift = SW'(shift);
    for (int i = 0; i < N; i++) drive(1'b1, v, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mixed"}, longint'(o_mixed), 0);
    chk({tag, "_rdy"}, longint'(o_rdy), 0);
    chk({tag, "_clip"}, longint'(o_clip), 0);
    chk({tag, "_sync_err"}, longint'(o_sync_err), 0);
    chk({tag, "_count"}, longint'(o_clip_count), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Partial frame then async reset in mid-cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 500, 1'b0, 1'b0);
    clk_en = 1'b0;
    #2 reset = 1'b1;
    #1 check_zero("midreset");
    m_cnt = 0; m_acc = 0; m_count = 0; sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    frame(100, 0);
    frame(MAXV, 0);
    frame(MAXV, 4);
    frame(MINV, 3);

    // Mixed-sign frame summing to -1, shift 1.
    i_shift = SW'(1);
    drive(1'b1, 5, 1'b0, 1'b0);
    drive(1'b1, -6, 1'b0, 1'b0);
    for (int i = 0; i < N - 2; i++) drive(1'b1, 0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);

    // Random clk_en gaps.
    i_shift = '0;
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) drive(1'b0, 99, 1'b0, 1'b0);
      drive(1'b1, 7, 1'b0, 1'b0);
    end
    drive(1'b0, 0, 1'b0, 1'b0);

    // Sync without clk_en is ignored, sync mid-frame flags an error, sync at frame start does not.
    for (int i = 0; i < 4; i++) drive(1'b1, 50, 1'b0, 1'b0);
    drive(1'b0, 1234, 1'b1, 1'b0);
    drive(1'b1, 50, 1'b1, 1'b0);
    for (int i = 0; i < N - 1; i++) drive(1'b1, 50, 1'b0, 1'b0);
    drive(1'b1, 50, 1'b1, 1'b0);
    for (int i = 0; i < N - 1; i++) drive(1'b1, 50, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);

    // Drive the clip counter to saturation, then one more clipping frame.
    while (m_count < CMAX) frame(MAXV, 0);
    frame(MINV, 0);
    chk("count_saturated", longint'(o_clip_count), CMAX);

    // Clear coincident with a clipping frame close.
    for (int i = 0; i < N - 1; i++) drive(1'b1, MAXV, 1'b0, 1'b0);
    drive(1'b1, MAXV, 1'b0, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0);
    chk("count_cleared", longint'(o_clip_count), 0);
    chk("clip_held", longint'(o_clip), 1);

    repeat (3) drive(1'b0, 0, 1'b0, 1'b0);
    chk("pending_frames", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_sum_mixer.md
Name: voice_sum_mixer

Overview:
- Sits between the voice bank manager and the sample ring buffer in the synthesizer top.
- Each clk_en cycle it accepts one voice sample from the bank manager's time-multiplexed output.
- It accumulates NVOICES consecutive samples, applies a per-frame arithmetic right-shift gain, and saturates the result to DW bits.
- It presents the mixed sample with a one-cycle ready pulse and keeps clip/sync statistics for software.

Parameters:
- NVOICES, 10, voice samples summed per output frame (>=1).
- DW, 24, signed sample width, input and output.
- SHIFT_W, 3, width of gain shift control.
- STAT_W, 16, width of clip statistics counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  sample-accept strobe; i_data is consumed on every clk edge where clk_en=1.
- i_data  in  DW  signed voice sample.
- i_sync  in  1  frame realign; qualified by clk_en; marks i_data as voice 0.
- i_shift  in  SHIFT_W  arithmetic right shift applied to the frame sum.
- i_clr_stats  in  1  synchronous clear of o_clip_count.
- o_mixed  out  DW  signed mixed sample, registered.
- o_rdy  out  1  one-cycle pulse: o_mixed updated.
- o_clip  out  1  last frame saturated; valid with o_rdy and held until the next frame.
- o_sync_err  out  1  one-cycle pulse: i_sync arrived mid-frame.
- o_clip_count  out  STAT_W  saturating count of clipped frames.

Behaviour:
- Reset (async, any time, including mid-frame):
  - Clears cnt=0, acc=0, o_mixed=0, o_rdy=0, o_clip=0, o_sync_err=0, o_clip_count=0.
  - Any partial frame is discarded.
- Internal state:
  - cnt, voice index, 0..NVOICES-1.
  - acc, signed, width AW = DW + clog2(NVOICES) + 1; every input is sign-extended to AW.
- clk_en=0: cnt, acc, o_mixed and o_clip hold; o_rdy=0 and o_sync_err=0 next cycle.
- clk_en=1, i_sync=0, cnt<NVOICES-1: acc <= acc + sext(i_data); cnt <= cnt+1; o_rdy=0.
- clk_en=1, i_sync=0, cnt==NVOICES-1 (frame close):
  - sum = acc + sext(i_data).
  - scaled = sum >>> i_shift. This is an arithmetic shift, truncating toward minus infinity. i_shift is sampled on this cycle only.
  - If scaled > 2^(DW-1)-1, o_mixed <= 2^(DW-1)-1 and o_clip <= 1.
  - If scaled < -2^(DW-1), o_mixed <= -2^(DW-1) and o_clip <= 1.
  - Otherwise o_mixed <= scaled[DW-1:0] and o_clip <= 0.
  - o_rdy <= 1 for exactly one cycle; acc <= 0; cnt <= 0.
  - On a clip, o_clip_count increments and saturates at all-ones.
- i_sync=1 with clk_en=1 (realign):
  - acc <= sext(i_data); cnt <= 1; no output produced.
  - o_sync_err pulses one cycle if cnt != 0 on that cycle; no pulse if cnt == 0.
  - NVOICES=1 exception: cnt stays 0 and the frame closes normally with i_data as the whole sum.
- i_sync without clk_en is ignored.
- Latency: o_mixed and o_rdy are valid on the cycle after the clk edge that accepted the last voice sample. Back-to-back frames are allowed, so throughput is one output per NVOICES accepted samples.
- NVOICES=1: every accepted sample closes a frame; o_rdy follows clk_en delayed one cycle.
- i_clr_stats:
  - Sets o_clip_count <= 0.
  - If asserted on the same cycle as a clipping frame close, the clear wins and the count becomes 0.
  - Does not affect o_clip.
- No back-pressure. The consumer must capture o_mixed while o_rdy=1 or before the next frame closes. The upstream full condition is handled by the consumer deasserting clk_en.

Test Plan:
- Assert reset mid-frame after 4 samples of 500 -> all outputs 0 immediately. After release, 10 samples of 100 with i_shift=0 -> o_mixed=1000, o_rdy high exactly 1 cycle after the 10th sample, o_clip=0.
- Ten samples of 8388607, i_shift=0 -> o_mixed=8388607, o_clip=1, o_clip_count=1. Repeat with i_shift=4 -> 83886070>>>4 gives o_mixed=5242879, o_clip=0, o_clip_count stays 1.
- Ten samples of -8388608:
  - i_shift=3 -> -10485760 gives o_mixed=-8388608, o_clip=1.
  - Then values 5,-6,0,... (sum -1) with i_shift=1 -> o_mixed=-1.
- Ten samples of 7 with clk_en toggled in a random pattern (gaps of 0-5 cycles) -> single o_rdy one cycle after the 10th accepted sample, o_mixed=70, no o_rdy during gaps.
- i_sync with sample 50 after 4 accepted samples -> o_sync_err 1-cycle pulse, then 9 more samples of 50 -> o_mixed=500. i_sync at cnt==0 -> no o_sync_err.
- Force o_clip_count to 65535 with clipping frames -> holds at 65535. i_clr_stats coincident with a clipping frame close -> o_clip_count=0.
